// File: rtl/id_hazard_unit.sv
// rtl/id_hazard_unit.sv - ID-stage hazard detection, operand forwarding and multi-cycle scoreboard
//
// Optional feature macro: ID_HAZARD_PERF_EN (adds stall_cycles / mc_full_cycles counters)
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   Ins_D                      instruction in ID (rs1 [15+:W], rs2 [20+:W], rd [7+:W])
//   use_rs1_D, use_rs2_D       ID instruction reads rs1 / rs2
//   RegWrite_D, branch_D, mc_D ID writes rd / resolves a branch in ID / is a MUL-DIV op
//   RegWrite_E, MemRead_E, rd_E, RegWrite_M, MemRead_M, rd_M, RegWrite_W, rd_W
//                              downstream stage write-back state
//   mc_done, mc_rd             multi-cycle result present on the W port this cycle
//   ForwardID_A, ForwardID_B   operand select: 0 = RF, 1 = WB, 2 = MEM
//   Stall_F, Stall_D, Flush_E  hazard controls
//   mc_outstanding             in-flight multi-cycle op count
//   stall_cycles, mc_full_cycles  saturating perf counters (ID_HAZARD_PERF_EN only)
//   sb_err                     sticky scoreboard protocol error
module id_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int MC_DEPTH   = 2,
  parameter int FWD_MEM    = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [31:0]                    Ins_D,
  input  logic                           use_rs1_D,
  input  logic                           use_rs2_D,
  input  logic                           RegWrite_D,
  input  logic                           branch_D,
  input  logic                           mc_D,
  input  logic                           RegWrite_E,
  input  logic                           MemRead_E,
  input  logic [REG_ADDR_W-1:0]          rd_E,
  input  logic                           RegWrite_M,
  input  logic                           MemRead_M,
  input  logic [REG_ADDR_W-1:0]          rd_M,
  input  logic                           RegWrite_W,
  input  logic [REG_ADDR_W-1:0]          rd_W,
  input  logic                           mc_done,
  input  logic [REG_ADDR_W-1:0]          mc_rd,
  output logic [1:0]                     ForwardID_A,
  output logic [1:0]                     ForwardID_B,
  output logic                           Stall_F,
  output logic                           Stall_D,
  output logic                           Flush_E,
  output logic [$clog2(MC_DEPTH+1)-1:0]  mc_outstanding,
`ifdef ID_HAZARD_PERF_EN
  output logic [31:0]                    stall_cycles,
  output logic [31:0]                    mc_full_cycles,
`endif
  output logic                           sb_err
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;
  localparam int CNT_W    = $clog2(MC_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MC_DEPTH);
  localparam logic FWD_MEM_EN = (FWD_MEM != 0);

  logic [REG_ADDR_W-1:0] rs1, rs2, rd_d;
  logic [NUM_REGS-1:0]   pending, pend_eff, done_vec, set_vec;
  logic e1, e2, m1, m2, w1, w2;
  logic load_use, branch_hz, raw_hz, waw_hz, cap_hz, hazard;
  logic done_ok, issue;
  logic unused_ins;

  assign rs1  = Ins_D[15 +: REG_ADDR_W];
  assign rs2  = Ins_D[20 +: REG_ADDR_W];
  assign rd_d = Ins_D[7 +: REG_ADDR_W];
  // Opcode/funct bits are decoded elsewhere; only the register fields matter here.
  assign unused_ins = ^Ins_D;

  function automatic logic stage_hit(input logic we, input logic [REG_ADDR_W-1:0] rd,
                                     input logic [REG_ADDR_W-1:0] rs, input logic use_rs);
    return we && (rd != '0) && (rd == rs) && use_rs;
  endfunction

  // A load still in MEM has no data yet, so it can never feed the MEM path.
  function automatic logic [1:0] fwd_sel(input logic m_hit, input logic w_hit, input logic m_load);
    if (FWD_MEM_EN && m_hit && !m_load) return 2'd2;
    if (w_hit)                         return 2'd1;
    return 2'd0;
  endfunction

  assign e1 = stage_hit(RegWrite_E, rd_E, rs1, use_rs1_D);
  assign e2 = stage_hit(RegWrite_E, rd_E, rs2, use_rs2_D);
  assign m1 = stage_hit(RegWrite_M, rd_M, rs1, use_rs1_D);
  assign m2 = stage_hit(RegWrite_M, rd_M, rs2, use_rs2_D);
  assign w1 = stage_hit(RegWrite_W, rd_W, rs1, use_rs1_D);
  assign w2 = stage_hit(RegWrite_W, rd_W, rs2, use_rs2_D);

  // A register whose multi-cycle result lands this cycle is no longer a hazard:
  // the consumer picks the value up through the WB forward path.
  assign done_vec = mc_done ? (NUM_REGS'(1) << mc_rd) : '0;
  assign pend_eff = pending & ~done_vec;
  assign set_vec  = (NUM_REGS'(1) << rd_d) & ~NUM_REGS'(1);

  assign load_use  = (e1 || e2) && MemRead_E;
  assign branch_hz = branch_D && (e1 || e2 || ((m1 || m2) && MemRead_M) ||
                                  (!FWD_MEM_EN && (m1 || m2)));
  assign raw_hz    = (use_rs1_D && pend_eff[rs1]) || (use_rs2_D && pend_eff[rs2]);
  assign waw_hz    = RegWrite_D && pend_eff[rd_d];
  assign cap_hz    = mc_D && (mc_outstanding == CNT_FULL);
  assign hazard    = !rst && (load_use || branch_hz || raw_hz || waw_hz || cap_hz);

  assign issue   = mc_D && RegWrite_D && !hazard && !rst;
  assign done_ok = mc_done && (mc_outstanding != '0) && pending[mc_rd];

  always_comb begin
    ForwardID_A = 2'd0;
    ForwardID_B = 2'd0;
    if (!rst) begin
      ForwardID_A = fwd_sel(m1, w1, MemRead_M);
      ForwardID_B = fwd_sel(m2, w2, MemRead_M);
    end
  end

  assign Stall_F = hazard;
  assign Stall_D = hazard;
  assign Flush_E = hazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending        <= '0;
      mc_outstanding <= '0;
      sb_err         <= 1'b0;
    end else begin
      // Clear first, then set, so a same-register issue/completion leaves the bit set.
      pending <= (pending & ~(done_ok ? done_vec : '0)) | (issue ? set_vec : '0);
      if (issue && !done_ok)
        mc_outstanding <= mc_outstanding + 1'b1;
      else if (!issue && done_ok)
        mc_outstanding <= mc_outstanding - 1'b1;
      if (mc_done && !done_ok)
        sb_err <= 1'b1;
    end
  end

`ifdef ID_HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles   <= '0;
      mc_full_cycles <= '0;
    end else begin
      if (hazard && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      if (cap_hz && (mc_full_cycles != '1))
        mc_full_cycles <= mc_full_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_hazard_unit.sv
// tb/tb_id_hazard_unit.sv - directed scoreboard bench for id_hazard_unit (FWD_MEM=1 and FWD_MEM=0 instances)
module tb_id_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] Ins_D;
  logic        use_rs1_D, use_rs2_D, RegWrite_D, branch_D, mc_D;
  logic        RegWrite_E, MemRead_E, RegWrite_M, MemRead_M, RegWrite_W, mc_done;
  logic [4:0]  rd_E, rd_M, rd_W, mc_rd;

  logic [1:0] fa, fb, fa0, fb0;
  logic       sf, sd, fe, sf0, sd0, fe0, err, err0;
  logic [1:0] cnt, cnt0;

  id_hazard_unit #(.REG_ADDR_W(5), .MC_DEPTH(2), .FWD_MEM(1)) dut (
    .clk(clk), .rst(rst), .Ins_D(Ins_D), .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D),
    .RegWrite_D(RegWrite_D), .branch_D(branch_D), .mc_D(mc_D),
    .RegWrite_E(RegWrite_E), .MemRead_E(MemRead_E), .rd_E(rd_E),
    .RegWrite_M(RegWrite_M), .MemRead_M(MemRead_M), .rd_M(rd_M),
    .RegWrite_W(RegWrite_W), .rd_W(rd_W), .mc_done(mc_done), .mc_rd(mc_rd),
    .ForwardID_A(fa), .ForwardID_B(fb), .Stall_F(sf), .Stall_D(sd), .Flush_E(fe),
    .mc_outstanding(cnt), .sb_err(err)
  );

  id_hazard_unit #(.REG_ADDR_W(5), .MC_DEPTH(2), .FWD_MEM(0)) dut0 (
    .clk(clk), .rst(rst), .Ins_D(Ins_D), .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D),
    .RegWrite_D(RegWrite_D), .branch_D(branch_D), .mc_D(mc_D),
    .RegWrite_E(RegWrite_E), .MemRead_E(MemRead_E), .rd_E(rd_E),
    .RegWrite_M(RegWrite_M), .MemRead_M(MemRead_M), .rd_M(rd_M),
    .RegWrite_W(RegWrite_W), .rd_W(rd_W), .mc_done(mc_done), .mc_rd(mc_rd),
    .ForwardID_A(fa0), .ForwardID_B(fb0), .Stall_F(sf0), .Stall_D(sd0), .Flush_E(fe0),
    .mc_outstanding(cnt0), .sb_err(err0)
  );

  typedef struct {
    string      tag;
    logic [1:0] fa, fb, fa0, fb0;
    logic       st, st0;
    logic [1:0] cnt;
    logic       err;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] ins(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    return {7'd0, r2, r1, 3'd0, rd, 7'h33};
  endfunction

  task automatic clr_in();
    Ins_D = 32'd0; use_rs1_D = 0; use_rs2_D = 0; RegWrite_D = 0; branch_D = 0; mc_D = 0;
    RegWrite_E = 0; MemRead_E = 0; rd_E = 0; RegWrite_M = 0; MemRead_M = 0; rd_M = 0;
    RegWrite_W = 0; rd_W = 0; mc_done = 0; mc_rd = 0;
  endtask

  // Inputs are already driven (just after a falling edge); record the expectation,
  // compare mid-phase, then move on to the next falling edge.
  task automatic step(input string tag, input logic [1:0] efa, input logic [1:0] efb, input logic est,
                      input logic [1:0] efa0, input logic [1:0] efb0, input logic est0,
                      input logic [1:0] ecnt, input logic eerr);
    exp_t e, g;
    e.tag = tag; e.fa = efa; e.fb = efb; e.st = est; e.fa0 = efa0; e.fb0 = efb0;
    e.st0 = est0; e.cnt = ecnt; e.err = eerr;
    q.push_back(e);
    #2;
    cmp({tag, ".qsize"}, 32'(q.size()), 32'd1);
    if (q.size() != 0) begin
      g = q.pop_front();
      cmp({g.tag, ".fa"},   32'(fa),   32'(g.fa));
      cmp({g.tag, ".fb"},   32'(fb),   32'(g.fb));
      cmp({g.tag, ".stf"},  32'(sf),   32'(g.st));
      cmp({g.tag, ".std"},  32'(sd),   32'(g.st));
      cmp({g.tag, ".fle"},  32'(fe),   32'(g.st));
      cmp({g.tag, ".cnt"},  32'(cnt),  32'(g.cnt));
      cmp({g.tag, ".err"},  32'(err),  32'(g.err));
      cmp({g.tag, ".fa0"},  32'(fa0),  32'(g.fa0));
      cmp({g.tag, ".fb0"},  32'(fb0),  32'(g.fb0));
      cmp({g.tag, ".std0"}, 32'(sd0),  32'(g.st0));
      cmp({g.tag, ".fle0"}, 32'(fe0),  32'(g.st0));
      cmp({g.tag, ".cnt0"}, 32'(cnt0), 32'(g.cnt));
      cmp({g.tag, ".err0"}, 32'(err0), 32'(g.err));
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    clr_in();
    @(negedge clk);

    // Reset: outputs held at 0 even with a load-use pattern present
    MemRead_E = 1; RegWrite_E = 1; rd_E = 5; Ins_D = ins(5, 0, 1); use_rs1_D = 1;
    step("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Load-use
    step("load_use", 0, 0, 1, 0, 0, 1, 0, 0);
    clr_in(); RegWrite_M = 1; MemRead_M = 1; rd_M = 5; Ins_D = ins(5, 0, 1); use_rs1_D = 1;
    step("load_in_m", 0, 0, 0, 0, 0, 0, 0, 0);

    // MEM over WB forwarding
    clr_in(); RegWrite_M = 1; rd_M = 7; RegWrite_W = 1; rd_W = 7; Ins_D = ins(0, 7, 1); use_rs2_D = 1;
    step("mem_fwd", 0, 2, 0, 0, 1, 0, 0, 0);
    RegWrite_M = 0;
    step("wb_fwd", 0, 1, 0, 0, 1, 0, 0, 0);
    use_rs2_D = 0;
    step("no_use", 0, 0, 0, 0, 0, 0, 0, 0);

    // Branch in ID
    clr_in(); branch_D = 1; Ins_D = ins(3, 0, 0); use_rs1_D = 1; RegWrite_E = 1; rd_E = 3;
    step("br_e", 0, 0, 1, 0, 0, 1, 0, 0);
    RegWrite_E = 0; RegWrite_M = 1; rd_M = 3;
    step("br_m_alu", 2, 0, 0, 0, 0, 1, 0, 0);
    MemRead_M = 1;
    step("br_m_load", 0, 0, 1, 0, 0, 1, 0, 0);

    // x0 never stalls or forwards
    clr_in(); branch_D = 1; Ins_D = ins(0, 0, 0); use_rs1_D = 1; use_rs2_D = 1;
    RegWrite_E = 1; MemRead_E = 1; rd_E = 0; RegWrite_M = 1; rd_M = 0; RegWrite_W = 1; rd_W = 0;
    step("x0", 0, 0, 0, 0, 0, 0, 0, 0);

    // Scoreboard: DIV to x9, consumer waits until the completion cycle
    clr_in(); mc_D = 1; RegWrite_D = 1; Ins_D = ins(0, 0, 9);
    step("div_issue", 0, 0, 0, 0, 0, 0, 0, 0);
    clr_in(); Ins_D = ins(9, 0, 1); use_rs1_D = 1;
    step("raw_wait1", 0, 0, 1, 0, 0, 1, 1, 0);
    step("raw_wait2", 0, 0, 1, 0, 0, 1, 1, 0);
    mc_done = 1; mc_rd = 9; RegWrite_W = 1; rd_W = 9;
    step("raw_done", 1, 0, 0, 1, 0, 0, 1, 0);
    clr_in(); Ins_D = ins(9, 0, 1); use_rs1_D = 1;
    step("raw_after", 0, 0, 0, 0, 0, 0, 0, 0);

    // Capacity
    clr_in(); mc_D = 1; RegWrite_D = 1; Ins_D = ins(0, 0, 10);
    step("issue10", 0, 0, 0, 0, 0, 0, 0, 0);
    Ins_D = ins(0, 0, 11);
    step("issue11", 0, 0, 0, 0, 0, 0, 1, 0);
    Ins_D = ins(0, 0, 12);
    step("cap_full", 0, 0, 1, 0, 0, 1, 2, 0);

    // WAW against an in-flight destination
    clr_in(); RegWrite_D = 1; Ins_D = ins(0, 0, 10);
    step("waw", 0, 0, 1, 0, 0, 1, 2, 0);

    // Drain x10, issue x4, drain x11
    clr_in(); mc_done = 1; mc_rd = 10;
    step("done10", 0, 0, 0, 0, 0, 0, 2, 0);
    clr_in(); mc_D = 1; RegWrite_D = 1; Ins_D = ins(0, 0, 4);
    step("issue4", 0, 0, 0, 0, 0, 0, 1, 0);
    clr_in(); mc_done = 1; mc_rd = 11;
    step("done11", 0, 0, 0, 0, 0, 0, 2, 0);

    // Same-cycle issue and completion of x4: bit stays set, counter unchanged
    clr_in(); mc_D = 1; RegWrite_D = 1; Ins_D = ins(0, 0, 4); mc_done = 1; mc_rd = 4;
    step("sim_issue_done", 0, 0, 0, 0, 0, 0, 1, 0);
    clr_in(); Ins_D = ins(4, 0, 1); use_rs1_D = 1;
    step("sim_pending", 0, 0, 1, 0, 0, 1, 1, 0);
    mc_done = 1; mc_rd = 4;
    step("sim_done", 0, 0, 0, 0, 0, 0, 1, 0);

    // Completion with nothing outstanding: sticky error, counter does not wrap
    clr_in(); mc_done = 1; mc_rd = 4;
    step("err_trig", 0, 0, 0, 0, 0, 0, 0, 0);
    clr_in();
    step("err_set", 0, 0, 0, 0, 0, 0, 0, 1);
    step("err_hold", 0, 0, 0, 0, 0, 0, 0, 1);

    // Reset mid-operation discards tracking
    mc_D = 1; RegWrite_D = 1; Ins_D = ins(0, 0, 9);
    step("pre_rst_issue", 0, 0, 0, 0, 0, 0, 0, 1);
    rst = 1'b1;
    @(negedge clk);
    clr_in(); RegWrite_E = 1; MemRead_E = 1; rd_E = 6; Ins_D = ins(6, 0, 1); use_rs1_D = 1;
    step("in_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    clr_in(); Ins_D = ins(9, 0, 1); use_rs1_D = 1;
    step("post_rst", 0, 0, 0, 0, 0, 0, 0, 0);

    cmp("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
